// File: rtl/madd_eval_pkg.sv
// rtl/madd_eval_pkg.sv - shared state enum, truncation mask and parameter range checks
package madd_eval_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MASK_MAX = 64;

  // Bit i set when column i survives truncation and lies inside the datapath.
  function automatic logic [MASK_MAX-1:0] trunc_mask(input int trunc, input int width);
    logic [MASK_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_MAX; i++) begin
      m[i] = (i >= trunc) && (i < width);
    end
    return m;
  endfunction

  function automatic bit out_w_ok(input int w, input int out_w);
    return (out_w >= 2) && (out_w <= 2 * w + 1);
  endfunction

  function automatic bit trunc_ok(input int w, input int trunc);
    return (trunc >= 0) && (trunc <= 2 * w - 1);
  endfunction

  function automatic bit width_ok(input int w);
    return (w >= 1) && (2 * w + 1 <= MASK_MAX);
  endfunction

endpackage

// File: rtl/madd_err_stats.sv
// rtl/madd_err_stats.sv - saturating operation and error-sum counters, clear has priority
module madd_err_stats
  import madd_eval_pkg::*;
#(
  parameter int EW     = 12,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stat_clr,
  input  logic              inc,
  input  logic [EW-1:0]     err_in,
  output logic [STAT_W-1:0] op_count,
  output logic [STAT_W-1:0] err_sum
);

  localparam int XW = ((STAT_W > EW) ? STAT_W : EW) + 1;
  localparam logic [XW-1:0] MAXV = XW'({STAT_W{1'b1}});

  logic [STAT_W-1:0] op_count_q, op_count_d;
  logic [STAT_W-1:0] err_sum_q, err_sum_d;
  logic [XW-1:0]     sum_wide;

  always_comb begin
    op_count_d = op_count_q;
    err_sum_d  = err_sum_q;
    sum_wide   = XW'(err_sum_q) + XW'(err_in);
    if (stat_clr) begin
      op_count_d = '0;
      err_sum_d  = '0;
    end else if (inc) begin
      if (op_count_q != {STAT_W{1'b1}}) op_count_d = op_count_q + 1'b1;
      err_sum_d = (sum_wide > MAXV) ? {STAT_W{1'b1}} : sum_wide[STAT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q <= '0;
      err_sum_q  <= '0;
    end else begin
      op_count_q <= op_count_d;
      err_sum_q  <= err_sum_d;
    end
  end

  assign op_count = op_count_q;
  assign err_sum  = err_sum_q;

endmodule

// File: rtl/madd_seq_approx_eval.sv
// rtl/madd_seq_approx_eval.sv - shift-add multiply-add producing exact and truncated results with error stats
module madd_seq_approx_eval
  import madd_eval_pkg::*;
#(
  parameter int W      = 6,
  parameter int OUT_W  = 12,
  parameter int TRUNC  = 3,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  input  logic [W-1:0]      c,
  input  logic              approx_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  y_approx,
  output logic [OUT_W-1:0]  y_exact,
  output logic [2*W-1:0]    err,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] op_count,
  output logic [STAT_W-1:0] err_sum
);

  localparam int AW = 2 * W + 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [MASK_MAX-1:0] MASK_FULL = trunc_mask(TRUNC, AW);
  localparam logic [AW-1:0] TMASK = MASK_FULL[AW-1:0];

  if (!width_ok(W)) begin : g_bad_w
    $error("madd_seq_approx_eval: W out of range");
  end
  if (!out_w_ok(W, OUT_W)) begin : g_bad_out_w
    $error("madd_seq_approx_eval: OUT_W out of range");
  end
  if (!trunc_ok(W, TRUNC)) begin : g_bad_trunc
    $error("madd_seq_approx_eval: TRUNC out of range");
  end

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic              approx_q, approx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     acc_ex_q, acc_ex_d;
  logic [AW-1:0]     acc_ap_q, acc_ap_d;
  logic [OUT_W-1:0]  y_exact_q, y_exact_d;
  logic [OUT_W-1:0]  y_approx_q, y_approx_d;
  logic [2*W-1:0]    err_q, err_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [AW-1:0]     pp, pp_ap, diff;
  logic              hs;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    approx_d    = approx_q;
    cnt_d       = cnt_q;
    acc_ex_d    = acc_ex_q;
    acc_ap_d    = acc_ap_q;
    y_exact_d   = y_exact_q;
    y_approx_d  = y_approx_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    pp          = '0;
    pp_ap       = '0;
    diff        = '0;
    hs          = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          approx_d   = approx_en;
          acc_ex_d   = AW'(c);
          acc_ap_d   = AW'(c);
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        pp       = b_q[cnt_q] ? (AW'(a_q) << cnt_q) : '0;
        pp_ap    = approx_q ? (pp & TMASK) : pp;
        acc_ex_d = acc_ex_q + pp;
        acc_ap_d = acc_ap_q + pp_ap;
        cnt_d    = cnt_q + 1'b1;
        // Truncated columns only ever remove value, so the difference is non-negative.
        diff     = acc_ex_d - acc_ap_d;
        if (cnt_q == CW'(W - 1)) begin
          y_exact_d   = acc_ex_d[OUT_W-1:0];
          y_approx_d  = acc_ap_d[OUT_W-1:0];
          err_d       = diff[2*W-1:0];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          hs          = 1'b1;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      approx_q    <= 1'b0;
      cnt_q       <= '0;
      acc_ex_q    <= '0;
      acc_ap_q    <= '0;
      y_exact_q   <= '0;
      y_approx_q  <= '0;
      err_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      approx_q    <= approx_d;
      cnt_q       <= cnt_d;
      acc_ex_q    <= acc_ex_d;
      acc_ap_q    <= acc_ap_d;
      y_exact_q   <= y_exact_d;
      y_approx_q  <= y_approx_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y_exact   = y_exact_q;
  assign y_approx  = y_approx_q;
  assign err       = err_q;

  madd_err_stats #(
    .EW     (2 * W),
    .STAT_W (STAT_W)
  ) u_stats (
    .clk      (clk),
    .rst      (rst),
    .stat_clr (stat_clr),
    .inc      (hs),
    .err_in   (err_q),
    .op_count (op_count),
    .err_sum  (err_sum)
  );

endmodule

// File: tb/tb_madd_seq_approx_eval.sv
// tb/tb_madd_seq_approx_eval.sv - randomized bench with column-level reference model, two OUT_W variants
module tb_madd_seq_approx_eval;

  localparam int W      = 6;
  localparam int OUT_W  = 12;
  localparam int OUT_W2 = 11;
  localparam int TRUNC  = 3;
  localparam int STAT_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              stat_clr = 1'b0;
  logic              approx_en = 1'b0;
  logic [W-1:0]      a = '0, b = '0, c = '0;

  logic              in_ready, out_valid;
  logic [OUT_W-1:0]  y_approx, y_exact;
  logic [2*W-1:0]    err;
  logic [STAT_W-1:0] op_count, err_sum;

  logic              w_in_ready, w_out_valid;
  logic [OUT_W2-1:0] w_y_approx, w_y_exact;
  logic [2*W-1:0]    w_err;
  logic [STAT_W-1:0] w_op_count, w_err_sum;

  int total = 0;
  int bad   = 0;
  longint unsigned m_ops = 0;
  longint unsigned m_sum = 0;
  longint unsigned stat_max = (64'd1 << STAT_W) - 1;

  madd_seq_approx_eval #(.W(W), .OUT_W(OUT_W), .TRUNC(TRUNC), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .approx_en(approx_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .y_approx(y_approx), .y_exact(y_exact), .err(err),
    .stat_clr(stat_clr), .op_count(op_count), .err_sum(err_sum)
  );

  madd_seq_approx_eval #(.W(W), .OUT_W(OUT_W2), .TRUNC(TRUNC), .STAT_W(STAT_W)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .a(a), .b(b), .c(c), .approx_en(approx_en),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .y_approx(w_y_approx), .y_exact(w_y_exact), .err(w_err),
    .stat_clr(stat_clr), .op_count(w_op_count), .err_sum(w_err_sum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Sum of single-bit partial products a[j]*b[i] at column i+j, dropping low columns in approx mode.
  function automatic void ref_model(input int av, input int bv, input int cv, input bit en,
                                    output longint unsigned ex, output longint unsigned ap);
    ex = longint'(av) * longint'(bv) + longint'(cv);
    ap = longint'(cv);
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (((av >> j) & 1) == 1 && ((bv >> i) & 1) == 1 && (!en || (i + j) >= TRUNC))
          ap += 64'd1 << (i + j);
  endfunction

  task automatic run_op(input int av, input int bv, input int cv, input bit en,
                        input int hold, input bit clr);
    longint unsigned ex, ap, e;
    int n;
    logic [OUT_W-1:0]  hy_ex, hy_ap;
    logic [2*W-1:0]    herr;
    ref_model(av, bv, cv, en, ex, ap);
    e = ex - ap;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    a = W'(av); b = W'(bv); c = W'(cv); approx_en = en; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); c = W'($urandom); approx_en = $urandom_range(0, 1);
    check("in_ready_busy", in_ready, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, W);
    check("y_exact", y_exact, ex & ((64'd1 << OUT_W) - 1));
    check("y_approx", y_approx, ap & ((64'd1 << OUT_W) - 1));
    check("err", err, e);
    check("w_y_exact", w_y_exact, ex & ((64'd1 << OUT_W2) - 1));
    check("w_y_approx", w_y_approx, ap & ((64'd1 << OUT_W2) - 1));
    check("w_err", w_err, e);
    check("in_ready_done", in_ready, 0);
    hy_ex = y_exact; hy_ap = y_approx; herr = err;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_ready", in_ready, 0);
      check("hold_y_exact", y_exact, hy_ex);
      check("hold_y_approx", y_approx, hy_ap);
      check("hold_err", herr, err);
    end
    out_ready = 1'b1;
    stat_clr = clr;
    @(posedge clk); #1;
    out_ready = 1'b0;
    stat_clr = 1'b0;
    in_valid = 1'b0;
    if (clr) begin
      m_ops = 0;
      m_sum = 0;
    end else begin
      if (m_ops < stat_max) m_ops++;
      m_sum = (m_sum + e > stat_max) ? stat_max : m_sum + e;
    end
    check("hs_out_valid", out_valid, 0);
    check("hs_in_ready", in_ready, 1);
    check("op_count", op_count, m_ops);
    check("err_sum", err_sum, m_sum);
  endtask

  task automatic reset_mid_op(input int busy_edges);
    @(negedge clk);
    a = 6'd45; b = 6'd27; c = 6'd9; approx_en = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (busy_edges) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_y_exact", y_exact, 0);
    check("rst_op_count", op_count, 0);
    check("rst_err_sum", err_sum, 0);
    m_ops = 0;
    m_sum = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_y_exact", y_exact, 0);
    check("reset_y_approx", y_approx, 0);
    check("reset_err", err, 0);
    check("reset_op_count", op_count, 0);
    check("reset_err_sum", err_sum, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(63, 63, 63, 1'b1, 0, 1'b0);
    run_op(1, 1, 0, 1'b1, 0, 1'b0);
    check("stats_two_ops", op_count, 2);
    check("stats_sum_18", err_sum, 18);
    run_op(1, 1, 0, 1'b0, 0, 1'b1);
    check("clr_op_count", op_count, 0);
    check("clr_err_sum", err_sum, 0);
    run_op(8, 8, 5, 1'b1, 10, 1'b0);
    run_op(63, 63, 63, 1'b0, 1, 1'b0);
    run_op(0, 0, 0, 1'b1, 0, 1'b0);
    run_op(63, 0, 63, 1'b1, 0, 1'b0);
    run_op(7, 7, 0, 1'b1, 2, 1'b0);

    reset_mid_op(3);
    run_op(63, 63, 63, 1'b1, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      run_op($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63),
             1'($urandom_range(0, 1)), $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/madd_seq_approx_eval.md
Name: madd_seq_approx_eval

Overview:
- Parametrised, sequential successor to the fixed 6x6+6 approximate multiply-add netlists.
- Computes y = a*b + c in two forms, both produced by the same shift-add datapath:
  - Exact: the true result.
  - Approximate: partial-product columns below TRUNC are zeroed.
- Reports the per-operation error distance and keeps running error statistics, so error evaluation runs in hardware next to the combinational approximate circuits.
- Sits behind a valid/ready stream source; results go to an error-logging sink.

Parameters:
- W, 6: operand width of a, b and c.
- OUT_W, 12: result width. Legal range is 2..2W+1; results are reduced mod 2^OUT_W.
- TRUNC, 3: count of least-significant product columns discarded in approx mode. Legal range is 0..2W-1.
- STAT_W, 32: width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept operands
- a  in  W  multiplicand
- b  in  W  multiplier
- c  in  W  addend (never truncated)
- approx_en  in  1  1 = apply truncation; sampled on accept
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- y_approx  out  OUT_W  approximate result mod 2^OUT_W
- y_exact  out  OUT_W  exact result mod 2^OUT_W
- err  out  2W  exact_full - approx_full, computed on full 2W+1-bit values; never negative
- stat_clr  in  1  synchronous clear of the statistics
- op_count  out  STAT_W  number of completed operations, saturating
- err_sum  out  STAT_W  sum of err over completed operations, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - State is IDLE.
  - in_ready=1 and out_valid=0.
  - y_approx, y_exact, err, op_count and err_sum are all 0.
  - Internal accumulators and the bit counter are 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - in_valid=1 at a clock edge latches a, b, c and approx_en.
  - Both accumulators (2W+1 bits) are loaded with zero-extended c.
  - cnt is set to 0 and the state moves to BUSY.
- BUSY:
  - in_ready=0. Each edge processes multiplier bit b[cnt].
  - If b[cnt]=1, add (a<<cnt) to the exact accumulator.
  - If b[cnt]=1, add (a<<cnt) with bits at positions <TRUNC cleared to the approx accumulator. Clearing applies only when approx_en=1.
  - cnt increments each edge. On the edge where cnt==W-1 the state moves to DONE.
- Latency: out_valid rises exactly W edges after the accepting edge. Both accumulators hold their final values at that point.
- Outputs are registered at the BUSY→DONE edge:
  - y_approx and y_exact are the low OUT_W bits of the accumulators.
  - err is the full-width difference.
- DONE:
  - out_valid=1. All outputs hold stable while out_ready=0; there is no timeout.
  - out_ready=1 at an edge completes the handshake and the state moves to IDLE.
  - At the same edge, op_count += 1 and err_sum += err, each saturating at 2^STAT_W-1.
  - in_ready stays 0 in DONE, so a new operation can be accepted at the earliest on the edge after the handshake. Minimum period is W+2 cycles.
- in_valid while in_ready=0 is ignored. Operands are not buffered, and the source must hold its operands until accepted.
- stat_clr:
  - stat_clr=1 zeroes op_count and err_sum at the next edge.
  - If it coincides with a DONE handshake, the clear wins: both counters read 0 afterwards.
  - It does not affect the FSM or the results.
- Mode control:
  - approx_en=0 gives y_approx==y_exact and err=0.
  - TRUNC=0 gives the same result for any approx_en.
- Reset mid-operation (in BUSY or DONE): immediate return to IDLE with all registers cleared. The pending result is lost and is not counted.
- Wrap: when OUT_W < 2W+1, high bits are dropped silently. err is always taken from the full-width values.

Decomposition:
- Shared package madd_eval_pkg holds:
  - the state enum (IDLE, BUSY, DONE);
  - the function trunc_mask(TRUNC, width), which returns the column mask;
  - elaboration checks on OUT_W and TRUNC ranges.
- One sub-module, madd_err_stats, holds the saturating op_count and err_sum counters with stat_clr priority.
- The FSM and both accumulators stay in the top module.

Test Plan:
- Exact multiply-add: W=6, TRUNC=3, a=63, b=63, c=63, approx_en=1 → y_exact=4032, y_approx=4015, err=17. out_valid appears 6 edges after accept.
- Lowest column dropped: a=1, b=1, c=0, approx_en=1 → y_exact=1, y_approx=0, err=1. With approx_en=0 the same operands give y_approx=1, err=0.
- No truncation effect: a=8, b=8, c=5, approx_en=1 → y_exact=y_approx=69, err=0. Then hold out_ready=0 for 10 cycles → outputs stable, in_ready=0, a new in_valid is ignored.
- Wrap: override OUT_W=11, a=63, b=63, c=63, approx_en=0 → y_exact=y_approx=1984, err=0.
- Statistics: run the first and second scenarios back to back → op_count=2, err_sum=18. Then assert stat_clr on the same edge as a third handshake → op_count=0, err_sum=0.
- Reset mid-operation: assert rst 3 cycles into BUSY → out_valid=0, in_ready=1 immediately, statistics unchanged at 0. A fresh operation after reset completes normally.
